// File: rtl/lbm_bram_arbiter.sv
// Four-port round-robin BRAM arbiter with per-requester burst lock and read-return tracking.
// Grants are combinational; BRAM address/data/we are registered and read data is tagged back to its requester.
module lbm_bram_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [3:0]            lock,
  input  logic [3:0]            we,
  input  logic [4*ADDR_W-1:0]   addr,
  input  logic [4*DATA_W-1:0]   wdata,
  output logic [3:0]            gnt,
  output logic [3:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  output logic                  mem_we,
  input  logic [DATA_W-1:0]     mem_dout
);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_owner;
  logic [1:0]          r_ptr;
  logic [1:0]          w_sel;
  logic [1:0]          w_idx;
  logic                w_acc;
  logic                w_hold;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_din;
  logic                w_we;

  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;
  logic                r_mem_we;
  logic                r_pv  [RD_LAT];
  logic [1:0]          r_pid [RD_LAT];
  logic [3:0]          r_rvalid;

  // Pointer always moves to (winner+1), so a released owner naturally resumes at owner+1.
  always_comb begin
    w_hold = (r_state == ST_LOCKED) && req[r_owner] && lock[r_owner];
    w_acc  = 1'b0;
    w_sel  = r_ptr;
    w_idx  = r_ptr;
    if (w_hold) begin
      w_acc = 1'b1;
      w_sel = r_owner;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        w_idx = r_ptr + 2'(k);
        if (!w_acc && req[w_idx]) begin
          w_acc = 1'b1;
          w_sel = w_idx;
        end
      end
    end

    gnt = '0;
    if (w_acc) gnt[w_sel] = 1'b1;

    w_state_nxt = (w_acc && lock[w_sel]) ? ST_LOCKED : ST_OPEN;

    w_addr = '0;
    w_din  = '0;
    w_we   = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (w_sel == 2'(k)) begin
        w_addr = addr[k*ADDR_W +: ADDR_W];
        w_din  = wdata[k*DATA_W +: DATA_W];
        w_we   = we[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OPEN;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_owner <= w_sel;
        r_ptr   <= w_sel + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_we   <= 1'b0;
    end else if (w_acc) begin
      r_mem_addr <= w_addr;
      r_mem_din  <= w_din;
      r_mem_we   <= w_we;
    end else begin
      r_mem_we   <= 1'b0;
    end
  end

  // Stage 0 lines up with mem_addr; the extra output register covers the BRAM latency edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_pv[i]  <= 1'b0;
        r_pid[i] <= '0;
      end
      r_rvalid <= '0;
    end else begin
      r_pv[0]  <= w_acc & ~w_we;
      r_pid[0] <= w_sel;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
      r_rvalid <= r_pv[RD_LAT-1] ? (4'b0001 << r_pid[RD_LAT-1]) : 4'b0000;
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_we   = r_mem_we;
  assign rvalid   = r_rvalid;
  assign rdata    = mem_dout;

endmodule

// File: tb/tb_lbm_bram_arbiter.sv
// Scoreboard bench for lbm_bram_arbiter: a driver predicts grants, BRAM issue and read returns
// from a behavioural arbitration model; a negedge monitor pops and compares.
module tb_lbm_bram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          req, lock, we;
  logic [4*ADDR_W-1:0] addr;
  logic [4*DATA_W-1:0] wdata;
  logic [3:0]          gnt, rvalid;
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_din;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_dout;

  lbm_bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural BRAM (read-first), 64 words used, with a preload port.
  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] bpipe [RD_LAT];
  logic              pre_we = 1'b0;
  logic [5:0]        pre_a = '0;
  logic [DATA_W-1:0] pre_d = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_we) mem[mem_addr[5:0]] <= mem_din;
    bpipe[0] <= mem[mem_addr[5:0]];
    for (int k = 1; k < RD_LAT; k++) bpipe[k] <= bpipe[k-1];
  end
  assign mem_dout = bpipe[RD_LAT-1];

  typedef struct { int due; logic [3:0] g; } gexp_t;
  typedef struct { int due; logic w; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } mexp_t;
  typedef struct { int due; logic [3:0] oh; logic [DATA_W-1:0] d; } rexp_t;
  gexp_t gq[$];
  mexp_t mq[$];
  rexp_t rq[$];

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model state: last granted requester, lock owner (-1 = none), last issued address/data.
  logic [DATA_W-1:0] ref_mem [64];
  int                m_last;
  int                m_owner;
  logic [ADDR_W-1:0] m_maddr;
  logic [DATA_W-1:0] m_mdin;
  logic              rel_pending = 1'b0;

  logic [3:0]        t_req, t_lock, t_we;
  logic [ADDR_W-1:0] t_a [4];
  logic [DATA_W-1:0] t_d [4];

  function automatic logic [DATA_W-1:0] pv(int i);
    return (i == 16) ? 16'h1234 : DATA_W'((i * 16'h0101) ^ 16'h5A5A);
  endfunction

  task automatic step();
    int         g;
    int         j;
    logic [3:0] eg;
    logic       mw;
    @(posedge clk); #1;
    if (rel_pending) begin
      rst = 1'b0;
      rel_pending = 1'b0;
    end
    req = t_req; lock = t_lock; we = t_we;
    for (int i = 0; i < 4; i++) begin
      addr[i*ADDR_W +: ADDR_W]  = t_a[i];
      wdata[i*DATA_W +: DATA_W] = t_d[i];
    end
    g = -1;
    if (m_owner >= 0 && t_req[m_owner] && t_lock[m_owner]) g = m_owner;
    else begin
      for (int k = 0; k < 4; k++) begin
        j = (m_last + 1 + k) % 4;
        if (g < 0 && t_req[j]) g = j;
      end
    end
    eg = '0;
    mw = 1'b0;
    if (g >= 0) begin
      eg[g]   = 1'b1;
      m_maddr = t_a[g];
      m_mdin  = t_d[g];
      mw      = t_we[g];
      if (t_we[g]) ref_mem[t_a[g][5:0]] = t_d[g];
      else rq.push_back('{due: cyc + 1 + RD_LAT, oh: eg, d: ref_mem[t_a[g][5:0]]});
      m_last  = g;
    end
    m_owner = (g >= 0 && t_lock[g]) ? g : -1;
    gq.push_back('{due: cyc, g: eg});
    mq.push_back('{due: cyc + 1, w: mw, a: m_maddr, d: m_mdin});
  endtask

  task automatic do_reset(int n);
    @(posedge clk); #1;
    rst = 1'b1; req = '0; lock = '0; we = '0;
    gq.delete(); mq.delete(); rq.delete();
    m_last = 3; m_owner = -1; m_maddr = '0; m_mdin = '0;
    repeat (n) @(posedge clk);
    rel_pending = 1'b1;
  endtask

  task automatic set_in(logic [3:0] r, logic [3:0] l, logic [3:0] w);
    t_req = r; t_lock = l; t_we = w;
    for (int i = 0; i < 4; i++) begin
      t_a[i] = '0;
      t_d[i] = '0;
    end
  endtask

  task automatic rand_steps(int n);
    repeat (n) begin
      t_req  = 4'($urandom);
      t_lock = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      t_we   = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        t_a[i] = ADDR_W'($urandom_range(0, 63));
        t_d[i] = DATA_W'($urandom);
      end
      step();
    end
  endtask

  task automatic idle(int n);
    set_in(4'b0000, 4'b0000, 4'b0000);
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    gexp_t ge;
    mexp_t me;
    rexp_t re;
    if (rst) begin
      if (!pre_we) begin
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_din", 32'(mem_din), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
      end
    end else begin
      if (gq.size() > 0 && gq[0].due == cyc) begin
        ge = gq.pop_front();
        chk("gnt", 32'(gnt), 32'(ge.g));
      end
      if (mq.size() > 0 && mq[0].due == cyc) begin
        me = mq.pop_front();
        chk("mem_we", 32'(mem_we), 32'(me.w));
        chk("mem_addr", 32'(mem_addr), 32'(me.a));
        chk("mem_din", 32'(mem_din), 32'(me.d));
      end
      if (rvalid != 4'b0000) begin
        if (rq.size() > 0 && rq[0].due == cyc) begin
          re = rq.pop_front();
          chk("rvalid", 32'(rvalid), 32'(re.oh));
          chk("rdata", 32'(rdata), 32'(re.d));
        end else begin
          chk("rvalid_unexpected", 32'(rvalid), 32'h0);
        end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        re = rq.pop_front();
        chk("rvalid_missing", 32'(rvalid), 32'(re.oh));
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    pre_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pre_a = 6'(i);
      pre_d = pv(i);
      ref_mem[i] = pv(i);
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    do_reset(2);
    set_in(4'b1111, 4'b0000, 4'b0000);
    repeat (8) step();

    set_in(4'b1010, 4'b0010, 4'b0000);
    repeat (5) step();
    set_in(4'b1010, 4'b0000, 4'b0000);
    step();
    step();

    set_in(4'b0100, 4'b0000, 4'b0000);
    t_a[2] = 13'h010;
    step();
    idle(3);

    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        set_in(4'b0001, 4'b0000, 4'b0000);
        t_a[0] = ADDR_W'(5 + i);
      end else begin
        set_in(4'b1000, 4'b0000, 4'b0000);
        t_a[3] = ADDR_W'(5 + i);
      end
      step();
    end
    idle(3);

    set_in(4'b0001, 4'b0000, 4'b0001);
    t_a[0] = 13'h003;
    t_d[0] = 16'hBEEF;
    step();
    set_in(4'b0010, 4'b0000, 4'b0000);
    t_a[1] = 13'h003;
    step();
    idle(3);

    rand_steps(300);

    set_in(4'b0001, 4'b0000, 4'b0000);
    t_a[0] = 13'h007;
    step();
    do_reset(2);
    set_in(4'b1111, 4'b0000, 4'b0000);
    step();
    idle(4);

    rand_steps(200);
    idle(RD_LAT + 4);

    @(negedge clk); #1;
    chk("drain_reads", 32'(rq.size()), 32'h0);
    chk("drain_gnt", 32'(gq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lbm_bram_arbiter.md
LBM_BRAM_ARBITER -- requirements
Module: lbm_bram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, meaning the BRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the BRAM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, range 1-4, meaning the BRAM read latency in cycles from a registered mem_addr to valid mem_dout.
REQ-004 The block SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port req  input  4  per-requester access request (0 stream, 1 bounce, 2 collide, 3 host).
REQ-007 The block SHALL have port lock  input  4  per-requester burst lock; only meaningful together with req.
REQ-008 The block SHALL have port we  input  4  per-requester write enable (1 write, 0 read).
REQ-009 The block SHALL have port addr  input  4*ADDR_W  packed per-requester address; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port wdata  input  4*DATA_W  packed per-requester write data; same slicing as addr.
REQ-011 The block SHALL have port gnt  output  4  one-hot or zero grant, combinational.
REQ-012 The block SHALL have port rvalid  output  4  one-hot read-data-valid, one pulse per accepted read.
REQ-013 The block SHALL have port rdata  output  DATA_W  read data, broadcast to all requesters, equal to mem_dout.
REQ-014 The block SHALL have port mem_addr  output  ADDR_W  registered BRAM address.
REQ-015 The block SHALL have port mem_din  output  DATA_W  registered BRAM write data.
REQ-016 The block SHALL have port mem_we  output  1  registered BRAM write enable.
REQ-017 The block SHALL have port mem_dout  input  DATA_W  BRAM read data.

Function
REQ-018 Acceptance: access of requester i SHALL be accepted in a cycle where req[i] and gnt[i] are both 1; at most one acceptance per cycle.
REQ-019 Round-robin: with no active lock, gnt SHALL go to the first requester with req=1, searching ptr, ptr+1, ... mod 4.
REQ-020 Pointer update: after an unlocked acceptance by i, ptr SHALL become (i+1) mod 4; ptr SHALL be unchanged in cycles with no acceptance.
REQ-021 Lock: acceptance by i with lock[i]=1 SHALL make i the owner; owner SHALL keep gnt on every cycle it holds req=1 and lock=1, whatever other requests are present.
REQ-022 Lock release: owner deasserting req or lock SHALL clear ownership in that cycle; arbitration then uses ptr=(owner+1) mod 4. A locked-then-released requester SHALL NOT be granted again before every other pending requester is served once.
REQ-023 Memory issue: on acceptance the next edge SHALL load mem_addr, mem_din and mem_we from the accepted slice; with no acceptance, mem_we SHALL be 0 and mem_addr/mem_din SHALL hold their values.
REQ-024 Read return: an accepted read by i SHALL pulse rvalid[i] exactly 1+RD_LAT cycles after the acceptance cycle; rdata is valid in that cycle.
REQ-025 Read tracking: a shift pipeline of depth RD_LAT, holding a valid bit and a 2-bit id, SHALL track reads; back-to-back reads by different requesters SHALL each return in order with the correct id.
REQ-026 Writes SHALL never produce rvalid.
REQ-027 Throughput: one access per cycle sustained, with no bubble between grants.
REQ-028 Grant SHALL be a function of req, lock, owner and ptr only, not of we or addr.

Reset
REQ-029 While rst=1, the block SHALL hold ptr=0, owner=none, mem_we=0, mem_addr=0, mem_din=0, rvalid=0, read pipeline cleared.
REQ-030 A reset during an in-flight read SHALL discard it; no rvalid pulse SHALL appear after reset release.
REQ-031 The first cycle after release with req=4'b1111 and lock=0 SHALL grant requester 0.

Verification
REQ-032 The bench SHALL cover: req=4'b1111 held 8 cycles, lock=0 -> gnt sequence 0,1,2,3,0,1,2,3 with no idle cycles.
REQ-033 The bench SHALL cover: req[2] read of addr 0x010 preloaded with 0x1234, RD_LAT=1 -> mem_addr=0x010 one cycle later, then rvalid=4'b0100 with rdata=0x1234 two cycles after acceptance.
REQ-034 The bench SHALL cover: requester 1 with lock=1 for 5 cycles while req[3]=1 -> gnt[1] for 5 cycles, then gnt[3], then gnt[1] not granted before gnt[3].
REQ-035 The bench SHALL cover: alternating reads by requesters 0 and 3 to addresses 5, 6, 7, 8 on consecutive cycles -> four rvalid pulses in order 0,3,0,3 with matching data.
REQ-036 The bench SHALL cover: requester 0 write of 0xBEEF to addr 3, then requester 1 read of addr 3 -> mem_we=1 for one cycle, no rvalid for requester 0, rvalid[1] with rdata=0xBEEF.
REQ-037 The bench SHALL cover: rst asserted the cycle after a read acceptance -> no rvalid after release, mem_we=0, next grant goes to requester 0.
